// File: rtl/gf4_mul_arbiter.sv
// Round-robin arbiter in front of one shared GF(2^4) multiplier (mod x^4+x+1)
// with a single registered, back-pressurable result stage. Define GF4_ARB_LOCK_EN to add req_lock.

module gf4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q
);
    assign q[0] = (a[0] & b[0]) ^ (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
    assign q[1] = (a[1] & b[0]) ^ ((a[0] ^ a[3]) & b[1]) ^ ((a[2] ^ a[3]) & b[2])
                ^ ((a[1] ^ a[2]) & b[3]);
    assign q[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ ((a[0] ^ a[3]) & b[2])
                ^ ((a[2] ^ a[3]) & b[3]);
    assign q[3] = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ ((a[0] ^ a[3]) & b[3]);
endmodule

module gf4_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
`ifdef GF4_ARB_LOCK_EN
    input  logic [NREQ-1:0]     req_lock,
`endif
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [3:0]          rsp_q
);
    // Handshake: a request transfers when req_valid[i] & req_ready[i]; req_valid must not
    // depend on req_ready and operands hold while waiting. The result transfers when
    // rsp_valid & rsp_ready; while rsp_valid & ~rsp_ready the result stage freezes.

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] ptr_nxt;
    logic           found;
    logic           stall;
    logic           accept;
    logic           lock_w;
    logic [3:0]     a_w;
    logic [3:0]     b_w;
    logic [3:0]     prod;
    int             idx;

    assign stall  = rsp_valid & ~rsp_ready;
    assign accept = found & ~stall & rst_n;

    // Rotating search starting at ptr; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_w = req_a[4*i +: 4];
                b_w = req_b[4*i +: 4];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

`ifdef GF4_ARB_LOCK_EN
    assign lock_w = req_lock[win];
`else
    assign lock_w = 1'b0;
`endif

    // A locked winner keeps top priority; otherwise priority moves past it.
    always_comb begin
        if (lock_w)                   ptr_nxt = win;
        else if (int'(win) == NREQ-1) ptr_nxt = '0;
        else                          ptr_nxt = win + IDW'(1);
    end

    gf4_mul u_mul (
        .a (a_w),
        .b (b_w),
        .q (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win;
            rsp_q     <= prod;
            ptr       <= ptr_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gf4_mul_arbiter.sv
// Self-checking bench for gf4_mul_arbiter against a behavioural reference model.
module tb_gf4_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
`ifdef GF4_ARB_LOCK_EN
    logic [NREQ-1:0]     req_lock = '0;
`endif
    logic [4*NREQ-1:0]   req_a = '0;
    logic [4*NREQ-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [3:0]          rsp_q;

    int n_checks = 0;
    int n_fail = 0;

    logic            m_valid;
    logic [IDW-1:0]  m_id;
    logic [3:0]      m_q;
    int              m_ptr;
    logic [NREQ-1:0] m_gnt;
    logic [IDW+3:0]  exp_q[$];

    gf4_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
`ifdef GF4_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'b0, a} << i);
        for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] ref_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        if (rst_n && !(m_valid && !rsp_ready)) begin
            w = ref_pick(req_valid, m_ptr);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = '0;
        m_q     = '0;
        m_ptr   = 0;
        m_gnt   = '0;
        exp_q.delete();
    endtask

    task automatic model_update();
        int w;
        logic lk;
        logic [3:0] q;
        m_gnt = ref_ready();
        w = -1;
        for (int i = 0; i < NREQ; i++) if (m_gnt[i]) w = i;
        if (w >= 0) begin
            q = ref_mul(req_a[4*w +: 4], req_b[4*w +: 4]);
            exp_q.push_back({w[IDW-1:0], q});
            m_valid = 1'b1;
            m_id    = w[IDW-1:0];
            m_q     = q;
            lk = 1'b0;
`ifdef GF4_ARB_LOCK_EN
            lk = req_lock[w];
`endif
            m_ptr = lk ? w : (w + 1) % NREQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go_idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = NREQ'($urandom_range(1, 15));
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
            n_checks++; if (rsp_q !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_q got=%h exp=0", rsp_q); end
            n_checks++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
            n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
            tick();
        end
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        tick();
    endtask

    task automatic test_single();
        go_idle();
        req_valid = 4'b0100;
        req_a = 16'h0200;
        req_b = 16'h0900;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
        n_checks++; if (rsp_q !== 4'h1) begin n_fail++; $display("FAIL single_q got=%h exp=1", rsp_q); end
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] exp_r [4];
        exp_r = '{4'h9, 4'hA, 4'hC, 4'h1};
        apply_reset();
        rsp_ready = 1'b1;
        req_a = 16'h28F3;
        req_b = 16'h98F7;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== (4'b0001 << k)) begin n_fail++; $display("FAIL contention_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << k); end
            if (k > 0) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(k - 1) || rsp_q !== exp_r[k-1])
                    begin n_fail++; $display("FAIL contention_rsp%0d got=%b/%0d/%h exp=1/%0d/%h", k - 1, rsp_valid, rsp_id, rsp_q, k - 1, exp_r[k-1]); end
            end
            tick();
            req_valid[k] = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_q !== exp_r[3])
            begin n_fail++; $display("FAIL contention_rsp3 got=%b/%0d/%h exp=1/3/%h", rsp_valid, rsp_id, rsp_q, exp_r[3]); end
        tick();
    endtask

    task automatic test_backpressure();
        int got;
        logic [IDW+3:0] e;
        go_idle();
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1111;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready_c%0d got=%b exp=0000", c, req_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== m_q)
                begin n_fail++; $display("FAIL bp_frozen_c%0d got=%b/%0d/%h exp=1/0/%h", c, rsp_valid, rsp_id, rsp_q, m_q); end
            tick();
        end
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== ref_ready()) begin n_fail++; $display("FAIL bp_grant got=%b exp=%b", req_ready, ref_ready()); end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra_result got=%0d/%h exp=none", rsp_id, rsp_q); end
                else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_q} !== e) begin n_fail++; $display("FAIL bp_result got=%0d/%h exp=%0d/%h", rsp_id, rsp_q, e[IDW+3:4], e[3:0]); end
                end
                got++;
            end
            tick();
            req_valid = req_valid & ~m_gnt;
        end
        n_checks++; if (got != 5 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_count got=%0d left=%0d exp=5/0", got, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        go_idle();
        req_valid = 4'b0010;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got=%b exp=1", rsp_valid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_drop got=%b exp=0", rsp_valid); end
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr0 got=%b exp=0001", req_ready); end
        tick();
    endtask

    task automatic test_random();
        int waitx [NREQ];
        logic [IDW+3:0] e;
        go_idle();
        for (int i = 0; i < NREQ; i++) waitx[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !m_gnt[i])) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_a[4*i +: 4] = 4'($urandom);
                    req_b[4*i +: 4] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            n_checks++; if (req_ready !== ref_ready()) begin n_fail++; $display("FAIL rand_grant c%0d got=%b exp=%b", c, req_ready, ref_ready()); end
            n_checks++; if (rsp_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c%0d got=%b exp=%b", c, rsp_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if (rsp_id !== m_id || rsp_q !== m_q) begin n_fail++; $display("FAIL rand_rsp c%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_q, m_id, m_q); end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra_result c%0d got=%0d/%h exp=none", c, rsp_id, rsp_q); end
                else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_q} !== e) begin n_fail++; $display("FAIL rand_sb c%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_q, e[IDW+3:4], e[3:0]); end
                end
            end
            tick();
            if (m_gnt != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_gnt[i] || !req_valid[i]) waitx[i] = 0;
                    else begin
                        waitx[i]++;
                        n_checks++; if (waitx[i] >= NREQ) begin n_fail++; $display("FAIL rand_fair req%0d waited=%0d limit=%0d", i, waitx[i], NREQ - 1); end
                    end
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) e = exp_q.pop_front();
            tick();
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost left=%0d exp=0", exp_q.size()); end
    endtask

`ifdef GF4_ARB_LOCK_EN
    task automatic test_lock();
        logic [NREQ-1:0] e;
        apply_reset();
        rsp_ready = 1'b1;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_valid = 4'b0110;
        req_lock = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) req_lock = '0;
            e = (k < 4) ? 4'b0010 : 4'b0100;
            @(negedge clk);
            n_checks++; if (req_ready !== e) begin n_fail++; $display("FAIL lock_grant%0d got=%b exp=%b", k, req_ready, e); end
            tick();
        end
        req_valid = '0;
        tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef GF4_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
